// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing one load/store at a time and forwarding results to wb and id
// Ports: clk, rst (async active-low); exe_to_mem_valid/data in, mem_allowin out;
//        wb_allowin in, mem_to_wb_valid/data out; mem_to_id_fw_data out;
//        data_req/wr/wstrb/addr/wdata out, data_addr_ok/data_ok/rdata in.
// Macro MEM_TO_ID_FW_EN enables the forwarding bundle; otherwise it is tied to zero.
module mem_stage #(
  parameter int EXE_TO_MEM_DATA_WD = 111,
  parameter int MEM_TO_WB_DATA_WD  = 70,
  parameter int MEM_TO_ID_FW_WD    = 39
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          exe_to_mem_valid,
  input  logic [EXE_TO_MEM_DATA_WD-1:0] exe_to_mem_data,
  output logic                          mem_allowin,
  input  logic                          wb_allowin,
  output logic                          mem_to_wb_valid,
  output logic [MEM_TO_WB_DATA_WD-1:0]  mem_to_wb_data,
  output logic [MEM_TO_ID_FW_WD-1:0]    mem_to_id_fw_data,
  output logic                          data_req,
  output logic                          data_wr,
  output logic [3:0]                    data_wstrb,
  output logic [31:0]                   data_addr,
  output logic [31:0]                   data_wdata,
  input  logic                          data_addr_ok,
  input  logic                          data_data_ok,
  input  logic [31:0]                   data_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic                          mem_valid;
  logic [1:0]                    state;
  logic [EXE_TO_MEM_DATA_WD-1:0] bundle;
  logic [31:0]                   rdata_r;
  logic                          unused_br;
  logic [2:0]                    store_op;
  logic [4:0]                    load_op, dest;
  logic                          rf_wen, is_mem, ready_go;
  logic [31:0]                   wdata, alu_result, pc, final_result;
  logic [1:0]                    a;
  logic [7:0]                    ld_b;
  logic [15:0]                   ld_h;
  assign {unused_br, store_op, load_op, dest, rf_wen, wdata, alu_result, pc} = bundle;
  assign is_mem          = |store_op || |load_op;
  assign ready_go        = !is_mem || state == DONE;
  assign mem_allowin     = !mem_valid || (ready_go && wb_allowin);
  assign mem_to_wb_valid = mem_valid && ready_go;
  assign a               = alu_result[1:0];
  assign ld_b            = 8'(rdata_r >> {a, 3'b000});
  assign ld_h            = 16'(rdata_r >> {a[1], 4'b0000});
  assign final_result    = load_op[4] ? {{24{ld_b[7]}}, ld_b} :
                           load_op[3] ? {{16{ld_h[15]}}, ld_h} :
                           load_op[2] ? rdata_r :
                           load_op[1] ? {24'b0, ld_b} :
                           load_op[0] ? {16'b0, ld_h} : alu_result;
  assign mem_to_wb_data  = {dest, rf_wen, final_result, pc};
  assign data_req        = state == REQ;
  assign data_wr         = data_req && |store_op;
  assign data_addr       = {alu_result[31:2], 2'b00};
  assign data_wstrb      = !data_req   ? 4'b0000 :
                           store_op[2] ? 4'b0001 << a :
                           store_op[1] ? 4'b0011 << {a[1], 1'b0} :
                           store_op[0] ? 4'b1111 : 4'b0000;
  assign data_wdata      = store_op[2] ? {4{wdata[7:0]}} :
                           store_op[1] ? {2{wdata[15:0]}} : wdata;
`ifdef MEM_TO_ID_FW_EN
  assign mem_to_id_fw_data = {mem_valid && is_mem && state != DONE, mem_valid && rf_wen, dest, final_result};
`else
  assign mem_to_id_fw_data = '0;
`endif
  // ok strobes outside the state expecting them fall through untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid <= 1'b0;
      state     <= IDLE;
      bundle    <= '0;
      rdata_r   <= '0;
    end else begin
      if (mem_allowin) mem_valid <= exe_to_mem_valid;
      if (exe_to_mem_valid && mem_allowin) bundle <= exe_to_mem_data;
      if (mem_allowin) state <= (exe_to_mem_valid && |exe_to_mem_data[109:102]) ? REQ : IDLE;
      else if (state == REQ && data_addr_ok) state <= WAIT;
      else if (state == WAIT && data_data_ok) begin
        state   <= DONE;
        rdata_r <= data_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random and directed stimulus for mem_stage checked against a transaction-level model
module tb_mem_stage;
  logic         clk = 1'b0, rst = 1'b0;
  logic         exe_to_mem_valid = 1'b0, wb_allowin = 1'b0;
  logic [110:0] exe_to_mem_data = '0;
  logic         mem_allowin, mem_to_wb_valid;
  logic [69:0]  mem_to_wb_data;
  logic [38:0]  mem_to_id_fw_data;
  logic         data_req, data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata;
  logic         data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0]  data_rdata = '0;
  int checks = 0, errors = 0;
`ifdef MEM_TO_ID_FW_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  mem_stage dut (
    .clk(clk), .rst(rst),
    .exe_to_mem_valid(exe_to_mem_valid), .exe_to_mem_data(exe_to_mem_data),
    .mem_allowin(mem_allowin), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_data(mem_to_wb_data),
    .mem_to_id_fw_data(mem_to_id_fw_data),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  function automatic logic [110:0] mk(input logic br, input logic [2:0] st, input logic [4:0] ld,
                                      input logic [4:0] dest, input logic we,
                                      input logic [31:0] wd, input logic [31:0] alu, input logic [31:0] pc);
    return {br, st, ld, dest, we, wd, alu, pc};
  endfunction

  function automatic logic is_mem_f(input logic [110:0] b);
    return |b[109:102];
  endfunction

  function automatic logic [31:0] ld_f(input logic [110:0] b, input logic [31:0] rd);
    int a;
    logic [31:0] by, hw;
    a  = int'(b[33:32]);
    by = (rd >> (8 * a)) & 32'hFF;
    hw = (rd >> (16 * (a / 2))) & 32'hFFFF;
    if (b[106]) return by[7] ? (by | 32'hFFFF_FF00) : by;
    if (b[105]) return hw[15] ? (hw | 32'hFFFF_0000) : hw;
    if (b[104]) return rd;
    if (b[103]) return by;
    if (b[102]) return hw;
    return b[63:32];
  endfunction

  function automatic logic [3:0] strb_f(input logic [110:0] b);
    int a;
    a = int'(b[33:32]);
    if (b[109]) return 4'(1 << a);
    if (b[108]) return 4'(3 << (a & 2));
    if (b[107]) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] wd_f(input logic [110:0] b);
    if (b[109]) return (b[95:64] & 32'hFF) * 32'h0101_0101;
    if (b[108]) return (b[95:64] & 32'hFFFF) * 32'h0001_0001;
    return b[95:64];
  endfunction

  // model: one held bundle, whether its address phase and data phase have completed
  logic         m_valid = 1'b0, m_addr = 1'b0, m_got = 1'b0;
  logic [110:0] m_b = '0;
  logic [31:0]  m_rd = '0;
  logic         e_mem, e_ready, e_allow, e_vld, e_req;
  logic [38:0]  e_fw, e_msk;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_addr = 1'b0; m_got = 1'b0; m_b = '0; m_rd = '0;
      chk("reset_ctl", {mem_allowin, mem_to_wb_valid, data_req, data_wr, data_wstrb}, 8'b1000_0000);
      chk("reset_wb", mem_to_wb_data, 70'h0);
      chk("reset_fw", mem_to_id_fw_data, 39'h0);
      chk("reset_bus", {data_addr, data_wdata}, 64'h0);
    end else begin
      e_mem   = m_valid && is_mem_f(m_b);
      e_ready = !is_mem_f(m_b) || m_got;
      e_allow = !m_valid || (e_ready && wb_allowin);
      e_vld   = m_valid && e_ready;
      e_req   = e_mem && !m_addr;
      chk("ctl", {mem_allowin, mem_to_wb_valid, data_req}, {e_allow, e_vld, e_req});
      if (e_vld) chk("wb_data", mem_to_wb_data, {m_b[101:97], m_b[96], ld_f(m_b, m_rd), m_b[31:0]});
      if (e_req) chk("req", {data_wr, data_wstrb, data_addr, data_wdata},
                     {|m_b[109:107], strb_f(m_b), m_b[63:34], 2'b00, wd_f(m_b)});
      e_fw  = FW ? {e_mem && !m_got, m_valid && m_b[96], m_b[101:97], ld_f(m_b, m_rd)} : 39'h0;
      e_msk = (FW && e_mem && !m_got) ? 39'h7F_0000_0000 : '1;
      chk("fw", mem_to_id_fw_data & e_msk, e_fw & e_msk);
      if (e_req && data_addr_ok) m_addr = 1'b1;
      else if (e_mem && m_addr && !m_got && data_data_ok) begin
        m_got = 1'b1;
        m_rd  = data_rdata;
      end
      if (e_allow) begin
        m_valid = exe_to_mem_valid;
        if (exe_to_mem_valid) begin
          m_b = exe_to_mem_data; m_addr = 1'b0; m_got = 1'b0;
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in;
    logic [2:0] st;
    logic [4:0] ld;
    int k;
    logic rq, wt;
    k  = int'($urandom % 10);
    st = 3'b0;
    ld = 5'b0;
    if (k >= 7) st = 3'(1 << ($urandom % 3));
    else if (k >= 4) ld = 5'(1 << ($urandom % 5));
    exe_to_mem_valid = 1'($urandom);
    exe_to_mem_data  = mk(1'($urandom), st, ld, 5'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    wb_allowin       = ($urandom % 4) != 0;
    rq = m_valid && is_mem_f(m_b) && !m_addr;
    wt = m_valid && is_mem_f(m_b) && m_addr && !m_got;
    data_addr_ok = rq ? ($urandom % 3 == 0) : (!wt && $urandom % 8 == 0);
    data_data_ok = wt ? ($urandom % 3 == 0) : (!rq && $urandom % 8 == 0);
    data_rdata   = $urandom;
  endtask

  initial begin
    int n;
    repeat (2) step;
    chk("rst_allowin", mem_allowin, 1'b1);
    chk("rst_req", {data_req, data_wr, data_wstrb}, 6'h0);
    chk("rst_wbv", mem_to_wb_valid, 1'b0);
    rst = 1'b1;
    step;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_data  = mk(1'b0, 3'b0, 5'b0, 5'd5, 1'b1, 32'h0, 32'h1234, 32'h100);
    wb_allowin       = 1'b1;
    step;
    exe_to_mem_valid = 1'b0;
    #1;
    chk("alu_valid", mem_to_wb_valid, 1'b1);
    chk("alu_result", mem_to_wb_data[63:32], 32'h1234);
    chk("alu_dest", mem_to_wb_data[69:65], 5'd5);
    step;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_data  = mk(1'b0, 3'b0, 5'b10000, 5'd3, 1'b1, 32'h0, 32'h1003, 32'h200);
    step;
    exe_to_mem_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      data_addr_ok = (i == 2);
      #1;
      if (i == 0) chk("lb_addr", data_addr, 32'h1000);
      n += int'(data_req);
      step;
    end
    data_addr_ok = 1'b0;
    chk("lb_req_cycles", n, 3);
    for (int i = 0; i < 3; i++) begin
      data_data_ok = (i == 2);
      data_rdata   = 32'h80FF_0000;
      #1;
      if (i == 0) begin
        chk("lb_wait_req", data_req, 1'b0);
        chk("fw_busy", mem_to_id_fw_data[38], FW);
      end
      step;
    end
    data_data_ok = 1'b0;
    #1;
    chk("lb_valid", mem_to_wb_valid, 1'b1);
    chk("lb_result", mem_to_wb_data[63:32], 32'hFFFF_FF80);
    chk("fw_done", mem_to_id_fw_data, FW ? {1'b0, 1'b1, 5'd3, 32'hFFFF_FF80} : 39'h0);
    step;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_data  = mk(1'b0, 3'b010, 5'b0, 5'd0, 1'b0, 32'h0000_ABCD, 32'h2002, 32'h300);
    step;
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    #1;
    chk("sh_wstrb", data_wstrb, 4'b1100);
    chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    chk("sh_wr", data_wr, 1'b1);
    step;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    #1;
    chk("sh_notready", mem_to_wb_valid, 1'b0);
    step;
    data_data_ok = 1'b0;
    #1;
    chk("sh_ready", mem_to_wb_valid, 1'b1);
    step;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_data  = mk(1'b0, 3'b0, 5'b00001, 5'd7, 1'b1, 32'h0, 32'h3002, 32'h400);
    step;
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    step;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h89AB_0000;
    wb_allowin   = 1'b0;
    step;
    data_data_ok = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lhu_stall", {mem_allowin, mem_to_wb_valid, mem_to_wb_data[63:32]}, {1'b0, 1'b1, 32'h0000_89AB});
      n += int'(data_req);
      step;
    end
    chk("lhu_noreq", n, 0);
    wb_allowin = 1'b1;
    step;
    exe_to_mem_valid = 1'b1;
    exe_to_mem_data  = mk(1'b0, 3'b0, 5'b00100, 5'd9, 1'b1, 32'h0, 32'h40, 32'h500);
    step;
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b1;
    step;
    data_addr_ok = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid", {mem_allowin, mem_to_wb_valid, data_req, data_wr, data_wstrb}, 8'b1000_0000);
    step;
    rst = 1'b1;
    step;
    data_data_ok = 1'b1;
    step;
    data_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stray_ok", {mem_to_wb_valid, data_req}, 2'b00);
      step;
    end
    repeat (3000) begin
      rnd_in();
      step;
    end
    exe_to_mem_valid = 1'b0;
    data_addr_ok     = 1'b0;
    data_data_ok     = 1'b0;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
